// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req_valid  fetch request valid              (fetch -> memory)
//   imem_req_ready  memory accepts the request       (memory -> fetch)
//   imem_req_addr   fetch address                    (fetch -> memory)
//   imem_rsp_valid  in-order response valid, no back-pressure (memory -> fetch)
//   imem_rsp_data   fetched instruction              (memory -> fetch)
// master = fetch stage side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage feeding decode. Holds the PC, issues in-order
// requests to instruction memory, buffers returned instructions together
// with their PCs and presents one instruction per cycle to decode. A redirect
// flushes the buffer and discards responses of requests already in flight.
//
// Ports
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   i_stall           decode stall, holds the current output instruction
//   i_redirect_valid  taken branch/jump from execute
//   i_redirect_pc     redirect target, bits [1:0] ignored
//   imem              instruction-memory bus (master side)
//   o_inst_fetched    instruction to decode (0 when none)
//   o_inst_valid      output instruction valid
//   o_inst_pc         PC of the output instruction (0 when none)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int              ILEN     = 32,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  fetch_stage_if.master   imem,
  output logic [ILEN-1:0] o_inst_fetched,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst_pc
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_iq_count;
  logic [AW-1:0]   r_iq_rd;
  logic [AW-1:0]   r_iq_wr;
  logic [AW-1:0]   r_pq_rd;
  logic [AW-1:0]   r_pq_wr;

  logic [ILEN-1:0] r_iq_data [QDEPTH];
  logic [XLEN-1:0] r_iq_pc   [QDEPTH];
  logic [XLEN-1:0] r_pq      [QDEPTH];

  logic [CW:0]     w_credit_used;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_iq_push;
  logic            w_iq_pop;
  logic            w_inst_valid;
  logic            w_unused_ok;

  // The low target bits are forced to zero, so they never reach any logic.
  assign w_unused_ok = ^i_redirect_pc[1:0];

  // Credits count both in-flight requests (stale ones included) and buffered
  // instructions, so every response is guaranteed a free FIFO slot.
  // Requests are also held off while reset is asserted.
  always_comb begin
    w_credit_used = {1'b0, r_outstanding} + {1'b0, r_iq_count};
    w_req_valid   = rst_n && !i_redirect_valid && (w_credit_used < (CW+1)'(QDEPTH));
    w_req_fire    = w_req_valid && imem.imem_req_ready;
    w_rsp_drop    = (r_drop_cnt != '0) || i_redirect_valid;
    w_iq_push     = imem.imem_rsp_valid && !w_rsp_drop;
    w_inst_valid  = (r_iq_count != '0);
    w_iq_pop      = w_inst_valid && !i_stall && !i_redirect_valid;
  end

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_pc;
  assign o_inst_valid        = w_inst_valid;
  assign o_inst_fetched      = w_inst_valid ? r_iq_data[r_iq_rd] : '0;
  assign o_inst_pc           = w_inst_valid ? r_iq_pc[r_iq_rd]   : '0;

  // FIFO storage needs no reset; validity is tracked by the pointers/counts.
  // A response is tagged with the PC at the head of the issued-PC FIFO.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pq[r_pq_wr] <= r_pc;
    end
    if (w_iq_push) begin
      r_iq_data[r_iq_wr] <= imem.imem_rsp_data;
      r_iq_pc[r_iq_wr]   <= r_pq[r_pq_rd];
    end
  end

  // Control state. The issued-PC FIFO and the outstanding counter track every
  // accepted request regardless of redirects; a redirect instead records how
  // many of those responses are stale and must be thrown away on arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_iq_count    <= '0;
      r_iq_rd       <= '0;
      r_iq_wr       <= '0;
      r_pq_rd       <= '0;
      r_pq_wr       <= '0;
    end else begin
      if (imem.imem_rsp_valid) begin
        r_pq_rd <= r_pq_rd + AW'(1);
      end
      if (w_req_fire) begin
        r_pq_wr <= r_pq_wr + AW'(1);
      end
      case ({w_req_fire, imem.imem_rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      if (i_redirect_valid) begin
        r_pc       <= {i_redirect_pc[XLEN-1:2], 2'b00};
        r_iq_rd    <= '0;
        r_iq_wr    <= '0;
        r_iq_count <= '0;
        // The response arriving in the redirect cycle is dropped right now.
        r_drop_cnt <= r_outstanding - CW'(imem.imem_rsp_valid);
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + XLEN'(4);
        end
        if (imem.imem_rsp_valid && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_iq_push) begin
          r_iq_wr <= r_iq_wr + AW'(1);
        end
        if (w_iq_pop) begin
          r_iq_rd <= r_iq_rd + AW'(1);
        end
        case ({w_iq_push, w_iq_pop})
          2'b10:   r_iq_count <= r_iq_count + CW'(1);
          2'b01:   r_iq_count <= r_iq_count - CW'(1);
          default: r_iq_count <= r_iq_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A behavioural memory answers requests with
// a configurable latency; a queue-based model of the fetch stage predicts the
// outputs every cycle. A second instance starts near the top of the address
// space to exercise PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int ILEN   = 32;
  localparam int XLEN   = 32;
  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redirPc = '0;
  logic [31:0] inst, ipc, inst2, ipc2;
  logic        ivalid, ivalid2;

  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(XLEN), .ILEN(ILEN)) mif ();
  fetch_stage_if #(.XLEN(XLEN), .ILEN(ILEN)) mif2 ();

  fetch_stage #(.ILEN(ILEN), .XLEN(XLEN), .RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_redirect_valid(redir),
    .i_redirect_pc(redirPc), .imem(mif), .o_inst_fetched(inst),
    .o_inst_valid(ivalid), .o_inst_pc(ipc)
  );

  fetch_stage #(.ILEN(ILEN), .XLEN(XLEN), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(QDEPTH)) dut2 (
    .clk(clk), .rst_n(rst2_n), .i_stall(1'b0), .i_redirect_valid(1'b0),
    .i_redirect_pc(32'h0), .imem(mif2), .o_inst_fetched(inst2),
    .o_inst_valid(ivalid2), .o_inst_pc(ipc2)
  );

  int nCompared = 0;
  int nMismatch = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Drive the decode/execute side for one cycle, just after the rising edge.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    stall   = s;
    redir   = r;
    redirPc = rpc;
  endtask

  // Behavioural instruction memory: fixed latency, in order, one response per cycle.
  typedef struct { logic [31:0] addr; int due; } memReq_t;
  memReq_t memQ[$];
  int cyc = 0;
  int lat = 1;
  bit readyMode = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst_n) begin
      mif.imem_rsp_valid = 1'b0;
      memQ.delete();
    end else if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      mif.imem_rsp_valid = 1'b1;
      mif.imem_rsp_data  = memData(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      mif.imem_rsp_valid = 1'b0;
      mif.imem_rsp_data  = '0;
    end
    mif.imem_req_ready = readyMode ? ((cyc % 3) != 0) : 1'b1;
  end

  // Model of the stage: in-flight requests carry a stale flag set by a redirect.
  typedef struct { logic [31:0] pc; bit stale; } flight_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
  flight_t     mFlight[$];
  ent_t        mBuf[$];
  flight_t     fl;
  logic [31:0] mPc = '0;
  logic [31:0] popLog[$];
  logic [31:0] seqNext = '0;
  bit          expReqValid;
  bit          doPop;

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_req_valid", mif.imem_req_valid, 32'd0);
      checkOutput("rst_req_addr", mif.imem_req_addr, 32'h0);
      checkOutput("rst_inst_valid", ivalid, 32'd0);
      checkOutput("rst_inst_pc", ipc, 32'h0);
      mPc = '0;
      seqNext = '0;
      mFlight.delete();
      mBuf.delete();
      memQ.delete();
    end else begin
      expReqValid = !redir && ((mFlight.size() + mBuf.size()) < QDEPTH);
      checkOutput("req_valid", mif.imem_req_valid, expReqValid);
      checkOutput("req_addr", mif.imem_req_addr, mPc);
      checkOutput("inst_valid", ivalid, mBuf.size() != 0);
      if (mBuf.size() != 0) begin
        checkOutput("inst_pc", ipc, mBuf[0].pc);
        checkOutput("inst_data", inst, mBuf[0].data);
      end else begin
        checkOutput("inst_pc_empty", ipc, 32'h0);
        checkOutput("inst_data_empty", inst, 32'h0);
      end
      doPop = (mBuf.size() != 0) && !stall && !redir;
      if (doPop) begin
        popLog.push_back(ipc);
        checkOutput("seq_pc", ipc, seqNext);
        checkOutput("seq_data", inst, memData(seqNext));
        seqNext = ipc + 32'd4;
      end
      if (mif.imem_req_valid && mif.imem_req_ready) begin
        memQ.push_back('{addr: mif.imem_req_addr, due: cyc + lat});
      end
      if (mif.imem_rsp_valid && mFlight.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end
      if (redir) begin
        if (mif.imem_rsp_valid && mFlight.size() != 0) void'(mFlight.pop_front());
        foreach (mFlight[i]) mFlight[i].stale = 1'b1;
        mBuf.delete();
        mPc = redirPc & ~32'h3;
        seqNext = mPc;
      end else begin
        if (doPop) void'(mBuf.pop_front());
        if (mif.imem_rsp_valid && mFlight.size() != 0) begin
          fl = mFlight.pop_front();
          if (!fl.stale) mBuf.push_back('{data: mif.imem_rsp_data, pc: fl.pc});
        end
        if (expReqValid && mif.imem_req_ready) begin
          mFlight.push_back('{pc: mPc, stale: 1'b0});
          mPc = mPc + 32'd4;
        end
      end
    end
  end

  // Second instance: always-ready 1-cycle memory, outputs logged for the wrap check.
  logic        pend2 = 1'b0;
  logic [31:0] pAddr2 = '0;
  logic [31:0] pop2[$];
  logic [31:0] popData2[$];

  always @(negedge clk) begin
    if (rst2_n) begin
      pend2  = mif2.imem_req_valid;
      pAddr2 = mif2.imem_req_addr;
      if (ivalid2) begin
        pop2.push_back(ipc2);
        popData2.push_back(inst2);
      end
    end else begin
      pend2 = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    mif2.imem_rsp_valid = pend2 && rst2_n;
    mif2.imem_rsp_data  = memData(pAddr2);
  end

  int idx;

  initial begin
    mif.imem_req_ready  = 1'b1;
    mif.imem_rsp_valid  = 1'b0;
    mif.imem_rsp_data   = '0;
    mif2.imem_req_ready = 1'b1;
    mif2.imem_rsp_valid = 1'b0;
    mif2.imem_rsp_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("wrap_rst_addr", mif2.imem_req_addr, 32'hFFFF_FFF8);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // Streaming start: request right away, first instruction two cycles later.
    @(negedge clk);
    checkOutput("start_req_valid", mif.imem_req_valid, 32'd1);
    checkOutput("start_req_addr", mif.imem_req_addr, 32'h0);
    checkOutput("start_inst_valid0", ivalid, 32'd0);
    @(negedge clk);
    checkOutput("start_inst_valid1", ivalid, 32'd0);
    @(negedge clk);
    checkOutput("start_inst_valid2", ivalid, 32'd1);
    checkOutput("start_inst_pc", ipc, 32'h0);
    checkOutput("start_inst_data", inst, 32'hDEAD_0000);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0);
    if (popLog.size() >= 4) begin
      checkOutput("stream_pc1", popLog[1], 32'h4);
      checkOutput("stream_pc2", popLog[2], 32'h8);
      checkOutput("stream_pc3", popLog[3], 32'hC);
    end else begin
      checkOutput("stream_count", popLog.size(), 32'd4);
    end

    // Stall for 6 cycles: output held, credits run out.
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("stall_hold_pc", ipc, seqNext);
      checkOutput("stall_hold_valid", ivalid, 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("stall_credit_off", mif.imem_req_valid, 32'd0);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0);

    // Intermittent ready.
    readyMode = 1'b1;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    readyMode = 1'b0;

    // Redirect with in-flight requests, 3-cycle memory.
    lat = 3;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0103);
    idx = popLog.size();
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redir_addr", mif.imem_req_addr, 32'h100);
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);
    if (popLog.size() > idx) checkOutput("redir_first_pc", popLog[idx], 32'h100);
    else checkOutput("redir_no_output", popLog.size(), idx + 1);

    // Back-to-back redirects: only the second target stream survives.
    applyStimulus(1'b0, 1'b1, 32'h0000_0200);
    applyStimulus(1'b0, 1'b1, 32'h0000_0300);
    idx = popLog.size();
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("b2b_addr", mif.imem_req_addr, 32'h300);
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);
    if (popLog.size() > idx) checkOutput("b2b_first_pc", popLog[idx], 32'h300);
    else checkOutput("b2b_no_output", popLog.size(), idx + 1);

    // Reset mid-stream: outputs clear before the next edge.
    lat = 1;
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_inst_valid", ivalid, 32'd0);
    checkOutput("async_inst_data", inst, 32'h0);
    checkOutput("async_inst_pc", ipc, 32'h0);
    checkOutput("async_req_valid", mif.imem_req_valid, 32'd0);
    checkOutput("async_req_addr", mif.imem_req_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idx = popLog.size();
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);
    if (popLog.size() > idx) checkOutput("rerun_first_pc", popLog[idx], 32'h0);
    else checkOutput("rerun_no_output", popLog.size(), idx + 1);

    // Wrap-around on the second instance.
    if (pop2.size() >= 3) begin
      checkOutput("wrap_pc0", pop2[0], 32'hFFFF_FFF8);
      checkOutput("wrap_pc1", pop2[1], 32'hFFFF_FFFC);
      checkOutput("wrap_pc2", pop2[2], 32'h0000_0000);
      checkOutput("wrap_data2", popData2[2], 32'hDEAD_0000);
    end else begin
      checkOutput("wrap_count", pop2.size(), 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
